// File: rtl/timepulse_gen.sv
// rtl/timepulse_gen.sv - AGC memory-cycle-time timepulse generator with monitor stop/step
module timepulse_gen #(
    parameter int DIV = 4,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mstp,
    input  logic          mstrt,
    output logic [11:0]   t,
    output logic          phs2,
    output logic          phs4,
    output logic          mct_end,
    output logic          stopped,
    output logic [CW-1:0] mct_cnt
);

    // Sub-timepulse counter width; a one-bit counter still covers DIV == 2.
    localparam int SW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(DIV - 1);
    localparam logic [SW-1:0] SUB_HALF = SW'(DIV / 2 - 1);
    localparam logic [11:0]   TP_T01   = 12'h001;

    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } mode_t;

    mode_t          mode_q;
    logic [11:0]    tp_q;
    logic [SW-1:0]  sub_q;
    logic [CW-1:0]  cnt_q;

    logic           run;
    logic           sub_last;
    logic           at_mct_end;
    logic [CW-1:0]  cnt_d;

    assign run        = (mode_q == RUN);
    assign sub_last   = (sub_q == SUB_LAST);
    assign at_mct_end = run && tp_q[11] && sub_last;
    assign cnt_d      = cnt_q + 1'b1;

    // Timing state machine: sub-step counter, timepulse ring, MCT counter and stop/step mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= RUN;
            tp_q   <= TP_T01;
            sub_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (mode_q)
                RUN: begin
                    if (!sub_last) begin
                        sub_q <= sub_q + 1'b1;
                    end else begin
                        sub_q <= '0;
                        if (tp_q[11]) begin
                            // MCT boundary: the only point where mstp is looked at.
                            cnt_q <= cnt_d;
                            tp_q  <= TP_T01;
                            if (mstp) begin
                                mode_q <= STOPPED;
                            end
                        end else begin
                            tp_q <= {tp_q[10:0], tp_q[11]};
                        end
                    end
                end
                STOPPED: begin
                    // Leave on a step pulse or once the stop request is withdrawn.
                    if (mstrt || !mstp) begin
                        mode_q <= RUN;
                        tp_q   <= TP_T01;
                        sub_q  <= '0;
                    end
                end
                default: begin
                    mode_q <= RUN;
                    tp_q   <= TP_T01;
                    sub_q  <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of state so the NOR network sees values that only move on posedge.
    assign t       = run ? tp_q : 12'h000;
    assign phs2    = run && (sub_q == SUB_HALF);
    assign phs4    = run && sub_last;
    assign mct_end = at_mct_end;
    assign stopped = (mode_q == STOPPED);
    assign mct_cnt = cnt_q;

endmodule

// File: tb/tb_timepulse_gen.sv
// tb/tb_timepulse_gen.sv - directed bench for timepulse_gen
module tb_timepulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        mstp;
    logic        mstrt;
    logic [11:0] t;
    logic        phs2, phs4, mct_end, stopped;
    logic [15:0] mct_cnt;

    logic        mstp_w  = 1'b0;
    logic        mstrt_w = 1'b0;
    logic [11:0] t_w;
    logic        phs2_w, phs4_w, mct_end_w, stopped_w;
    logic [3:0]  mct_cnt_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timepulse_gen #(.DIV(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .mstp(mstp), .mstrt(mstrt),
        .t(t), .phs2(phs2), .phs4(phs4), .mct_end(mct_end),
        .stopped(stopped), .mct_cnt(mct_cnt)
    );

    timepulse_gen #(.DIV(4), .CW(4)) dut_w (
        .clk(clk), .rst(rst), .mstp(mstp_w), .mstrt(mstrt_w),
        .t(t_w), .phs2(phs2_w), .phs4(phs4_w), .mct_end(mct_end_w),
        .stopped(stopped_w), .mct_cnt(mct_cnt_w)
    );

    typedef struct {
        int          cyc;
        logic [11:0] t;
        logic        phs2;
        logic        phs4;
        logic        mct_end;
        logic        stopped;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; invariants checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot_t", {31'd0, $onehot0(t)}, 32'd1);
        chk("onehot_t_w", {31'd0, $onehot0(t_w)}, 32'd1);
        if (stopped) chk("stopped_t_zero", {20'd0, t}, 32'd0);
    endtask

    initial begin
        int vi;
        int runc;

        vecs[0]  = '{0,  12'h001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1,  12'h001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{2,  12'h001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{3,  12'h001, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{4,  12'h002, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{5,  12'h002, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{7,  12'h002, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{8,  12'h004, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{44, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[9]  = '{47, 12'h800, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[10] = '{48, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{96, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

        rst = 1'b1; mstp = 1'b0; mstrt = 1'b0;
        #2;

        // Free run after reset.
        tick();
        rst = 1'b0;
        vi = 0;
        for (int c = 0; c <= 96; c++) begin
            chk("fr_mct_end", {31'd0, mct_end}, {31'd0, (c % 48) == 47});
            if (vi < NV && vecs[vi].cyc == c) begin
                chk("fr_t",       {20'd0, t},       {20'd0, vecs[vi].t});
                chk("fr_phs2",    {31'd0, phs2},    {31'd0, vecs[vi].phs2});
                chk("fr_phs4",    {31'd0, phs4},    {31'd0, vecs[vi].phs4});
                chk("fr_mct_end_v", {31'd0, mct_end}, {31'd0, vecs[vi].mct_end});
                chk("fr_stopped", {31'd0, stopped}, {31'd0, vecs[vi].stopped});
                chk("fr_cnt",     {16'd0, mct_cnt}, {16'd0, vecs[vi].cnt});
                vi++;
            end
            if (c < 96) tick();
        end
        chk("fr_all_vectors_seen", vi, NV);

        // Stop at boundary with mstp held from reset.
        rst = 1'b1; mstp = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 48; c++) begin
            chk("stop_run_t", {20'd0, t}, {20'd0, 12'h001 << (c / 4)});
            chk("stop_run_stopped", {31'd0, stopped}, 32'd0);
            tick();
        end
        for (int c = 0; c < 100; c++) begin
            chk("stop_hold", {12'd0, stopped, t, phs2, phs4, mct_cnt},
                             {12'd0, 1'b1, 12'h000, 1'b0, 1'b0, 16'd1});
            tick();
        end

        // Single step, with a stray mstrt pulse mid-MCT.
        mstrt = 1'b1;
        tick();
        mstrt = 1'b0;
        chk("step_first_t01", {20'd0, t}, 32'h001);
        runc = 0;
        for (int k = 0; k < 200 && !stopped; k++) begin
            if (t != 12'h000) runc++;
            mstrt = (runc == 20);
            tick();
        end
        mstrt = 1'b0;
        chk("step_run_cycles", runc, 48);
        chk("step_stopped", {31'd0, stopped}, 32'd1);
        chk("step_cnt", {16'd0, mct_cnt}, 32'd2);

        // Late stop: mstp pulse inside the MCT is ignored.
        mstp = 1'b0;
        tick();
        chk("late_resume_t01", {20'd0, t}, 32'h001);
        for (int c = 0; c < 48; c++) begin
            if (c == 17) mstp = 1'b1;
            if (c == 37) mstp = 1'b0;
            tick();
        end
        chk("late_not_stopped", {31'd0, stopped}, 32'd0);
        chk("late_t01", {20'd0, t}, 32'h001);
        chk("late_cnt", {16'd0, mct_cnt}, 32'd3);
        // mstp raised in T12 sub=1 takes effect at this MCT end.
        for (int c = 0; c < 48; c++) begin
            if (c == 45) begin
                chk("late_t12", {20'd0, t}, 32'h800);
                mstp = 1'b1;
            end
            tick();
        end
        chk("late_stop", {31'd0, stopped}, 32'd1);
        chk("late_stop_cnt", {16'd0, mct_cnt}, 32'd4);

        // Reset while stopped.
        rst = 1'b1;
        tick();
        rst = 1'b0; mstp = 1'b0;
        chk("rst_stop_stopped", {31'd0, stopped}, 32'd0);
        chk("rst_stop_t", {20'd0, t}, 32'h001);
        chk("rst_stop_cnt", {16'd0, mct_cnt}, 32'd0);

        // Reset mid-MCT at T07 sub=2.
        for (int c = 0; c < 48 + 26; c++) tick();
        chk("rst_mid_pre_t", {20'd0, t}, 32'h040);
        chk("rst_mid_pre_cnt", {16'd0, mct_cnt}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_t", {20'd0, t}, 32'h001);
        chk("rst_mid_cnt", {16'd0, mct_cnt}, 32'd0);
        chk("rst_mid_phs2_sub0", {31'd0, phs2}, 32'd0);
        tick();
        chk("rst_mid_phs2_sub1", {31'd0, phs2}, 32'd1);

        // Counter wrap on the CW=4 instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 15 * 48; c++) tick();
        chk("wrap_cnt_15", {28'd0, mct_cnt_w}, 32'd15);
        for (int c = 0; c < 48; c++) tick();
        chk("wrap_cnt_0", {28'd0, mct_cnt_w}, 32'd0);
        chk("wrap_t01", {20'd0, t_w}, 32'h001);
        chk("wrap_main_cnt_16", {16'd0, mct_cnt}, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
